// File: rtl/ncl_pkg.sv
// Shared NCL definitions: dual-rail widths, NULL wavefront,
// transmitter states and the binary to dual-rail encoder.
package ncl_pkg;

  localparam int OPW = 4;
  localparam int DRW = 2 * OPW;

  localparam logic [DRW-1:0] NCL_NULL = '0;

  typedef enum logic [1:0] {
    WAIT_NULL,
    IDLE,
    DATA
  } state_t;

  typedef struct packed {
    logic           cin;
    logic [OPW-1:0] b;
    logic [OPW-1:0] a;
  } word_t;

  // Pair i is {rail1, rail0}: 10 for a one, 01 for a zero.
  function automatic logic [DRW-1:0] dr_encode(
    input logic [OPW-1:0] bin,
    input int             width
  );
    logic [DRW-1:0] dr;
    dr = NCL_NULL;
    for (int i = 0; i < OPW; i++) begin
      if (i < width) begin
        dr[2*i +: 2] = bin[i] ? 2'b10 : 2'b01;
      end
    end
    return dr;
  endfunction

endpackage

// File: rtl/ncl_ack_sync.sv
// Two-flop synchronizer for the asynchronous NCL acknowledge.
// Both flops clear to 0 on the asynchronous active-low reset.
module ncl_ack_sync (
  input  logic clk,
  input  logic reset,
  input  logic ack,
  output logic ack_s
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta  <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      meta  <= ack;
      ack_s <= meta;
    end
  end

endmodule

// File: rtl/ncl_dual_rail_tx.sv
// Synchronous-to-NCL transmitter: FIFO, dual-rail encode, DATA/NULL pacing.
// Optional phase timeout flag built when NCL_TX_TIMEOUT_EN is defined.
module ncl_dual_rail_tx
  import ncl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  input  logic           in_cin,
  input  logic           ack_in,
  output logic [DRW-1:0] a,
  output logic [DRW-1:0] b,
  output logic [1:0]     cin,
  output logic [15:0]    tx_count,
  output logic           err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic          ack_s;
  word_t         mem [DEPTH];
  word_t         in_word;
  word_t         head;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  state_t        state_q;
  state_t        state_d;
  logic          load_data;
  logic          load_null;
  logic [1:0]    warm;
  logic [DRW-1:0] enc_a;
  logic [DRW-1:0] enc_b;
  logic [1:0]    enc_c;

  ncl_ack_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .ack   (ack_in),
    .ack_s (ack_s)
  );

  assign in_word = '{cin: in_cin, b: in_b, a: in_a};
  assign head    = mem[rd_ptr[AW-1:0]];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready = !full;
  assign push     = in_valid && !full;

  assign enc_a = dr_encode(head.a, OPW);
  assign enc_b = dr_encode(head.b, OPW);
  assign enc_c = 2'(dr_encode(OPW'(head.cin), 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_word;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_data = 1'b0;
    load_null = 1'b0;
    unique case (state_q)
      // wait for a genuine post-reset synchronizer sample
      WAIT_NULL: begin
        if (!ack_s && warm[1]) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!empty) begin
          load_data = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (ack_s) begin
          load_null = 1'b1;
          state_d   = WAIT_NULL;
        end
      end
      default: state_d = WAIT_NULL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= WAIT_NULL;
      warm     <= 2'b00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      a        <= NCL_NULL;
      b        <= NCL_NULL;
      cin      <= 2'b00;
      tx_count <= 16'd0;
    end else begin
      state_q <= state_d;
      warm    <= {warm[0], 1'b1};
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (load_data) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        a      <= enc_a;
        b      <= enc_b;
        cin    <= enc_c;
      end else if (load_null) begin
        a        <= NCL_NULL;
        b        <= NCL_NULL;
        cin      <= 2'b00;
        tx_count <= tx_count + 16'd1;
      end
    end
  end

`ifdef NCL_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] phase_cnt;
  logic          hold;

  assign hold = (state_d == state_q) && (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (!hold) begin
        phase_cnt <= '0;
      end else if (phase_cnt != TW'(TIMEOUT)) begin
        phase_cnt <= phase_cnt + TW'(1);
      end
      if (hold && phase_cnt == TW'(TIMEOUT - 1)) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0 & (TIMEOUT != 0);
`endif

endmodule
